// File: rtl/lc3b_mem_responder_pkg.sv
// Shared LC-3b types used by the memory responder slice.
//   lc3b_word      : 16-bit data/address word
//   lc3b_mem_wmask : byte write enables, bit 1 -> [15:8], bit 0 -> [7:0]
//   lc3b_mem_state : responder FSM state
//   merge_word     : apply a byte mask of new data over an old word
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        s_idle,
        s_wait,
        s_resp
    } lc3b_mem_state;

    function automatic lc3b_word merge_word(input lc3b_word old_word,
                                            input lc3b_word new_word,
                                            input lc3b_mem_wmask wmask);
        lc3b_word result;
        result[15:8] = wmask[1] ? new_word[15:8] : old_word[15:8];
        result[7:0]  = wmask[0] ? new_word[7:0]  : old_word[7:0];
        return result;
    endfunction

endpackage

// File: rtl/lc3b_mem_responder_if.sv
// CPU <-> memory request/response bundle.
//   master : CPU side, drives requests, receives rdata/resp
//   slave  : memory side, receives requests, drives rdata/resp
interface lc3b_mem_responder_if;
    import lc3b_types::*;

    logic          mem_read;
    logic          mem_write;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    lc3b_mem_wmask mem_wmask;
    lc3b_word      mem_rdata;
    logic          mem_resp;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_wmask,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_wmask,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/lc3b_mem_responder_array.sv
// Word store of 2^ADDR_BITS x 16 bits.
//   clk   : write clock
//   we    : write enable
//   wmask : per-byte write enables
//   index : word index (shared by read and write)
//   wdata : write data
//   rdata : combinational read of store[index]
// Contents are deliberately not reset.
module lc3b_mem_array
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  lc3b_mem_wmask        wmask,
    input  logic [ADDR_BITS-1:0] index,
    input  lc3b_word             wdata,
    output lc3b_word             rdata
);

    lc3b_word store [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            if (wmask[1]) store[index][15:8] <= wdata[15:8];
            if (wmask[0]) store[index][7:0]  <= wdata[7:0];
        end
    end

    assign rdata = store[index];

endmodule

// File: rtl/lc3b_mem_responder.sv
// Multi-cycle memory responder for the LC-3b CPU.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of the CPU memory bundle
// A request seen in IDLE is captured and answered LATENCY cycles later
// with a one-cycle mem_resp; the store is updated on the edge entering RESP.
module lc3b_mem_responder
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    lc3b_mem_responder_if.slave   bus
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    lc3b_mem_state        state, state_next;
    logic [3:0]           cnt, cnt_next;
    logic                 capture, enter_resp;

    logic                 op_write_q;
    logic [ADDR_BITS-1:0] index_q;
    lc3b_word             wdata_q;
    lc3b_mem_wmask        wmask_q;

    logic                 cur_write;
    logic [ADDR_BITS-1:0] cur_index;
    lc3b_word             cur_wdata;
    lc3b_mem_wmask        cur_wmask;
    lc3b_word             arr_rdata;

    lc3b_word             rdata_q;
    logic                 resp_q;

    logic                 unused_addr_bits;
    assign unused_addr_bits = ^bus.mem_address;

    // With LATENCY=1 the store is touched on the accepting edge itself,
    // so the live request fields must feed the array while in IDLE.
    always_comb begin
        if (state == s_idle) begin
            cur_write = bus.mem_write;
            cur_index = bus.mem_address[ADDR_BITS:1];
            cur_wdata = bus.mem_wdata;
            cur_wmask = bus.mem_wmask;
        end else begin
            cur_write = op_write_q;
            cur_index = index_q;
            cur_wdata = wdata_q;
            cur_wmask = wmask_q;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        enter_resp = 1'b0;
        case (state)
            s_idle: begin
                if (bus.mem_read || bus.mem_write) begin
                    capture  = 1'b1;
                    cnt_next = LAT_M1;
                    if (LATENCY == 1) begin
                        state_next = s_resp;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = s_wait;
                    end
                end
            end
            s_wait: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = s_resp;
                    enter_resp = 1'b1;
                end
            end
            s_resp: state_next = s_idle;
            default: state_next = s_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= s_idle;
            cnt        <= 4'd0;
            op_write_q <= 1'b0;
            index_q    <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
            resp_q     <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            resp_q <= enter_resp;
            if (capture) begin
                op_write_q <= bus.mem_write;
                index_q    <= bus.mem_address[ADDR_BITS:1];
                wdata_q    <= bus.mem_wdata;
                wmask_q    <= bus.mem_wmask;
            end
            if (enter_resp) begin
                rdata_q <= cur_write ? merge_word(arr_rdata, cur_wdata, cur_wmask)
                                     : arr_rdata;
            end
        end
    end

    // Reset gates the write so an in-flight write is never committed.
    lc3b_mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk   (clk),
        .we    (enter_resp && cur_write && !reset),
        .wmask (cur_wmask),
        .index (cur_index),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_resp  = resp_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
module tb_lc3b_mem_responder;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    lc3b_mem_responder_if bus4 ();
    lc3b_mem_responder_if bus1 ();

    lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One LATENCY=4 access: driven in the cycle after the current one,
    // mem_resp checked on each of the following four cycles.
    task automatic access4(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wd, input logic [1:0] mask,
                           input logic hold, input logic [15:0] exp_data,
                           input string tag);
        @(posedge clk); #1;
        bus4.mem_read    = rd;
        bus4.mem_write   = wr;
        bus4.mem_address = addr;
        bus4.mem_wdata   = wd;
        bus4.mem_wmask   = mask;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check({tag, "_resp"}, {15'd0, bus4.mem_resp}, {15'd0, (k == 4)});
            if (k == 4) check({tag, "_rdata"}, bus4.mem_rdata, exp_data);
            if (!hold && k == 1) begin
                bus4.mem_read    = 1'b0;
                bus4.mem_write   = 1'b0;
                bus4.mem_address = 16'hFFFF;
                bus4.mem_wdata   = 16'h0000;
                bus4.mem_wmask   = 2'b11;
            end
        end
        bus4.mem_read  = 1'b0;
        bus4.mem_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus4.mem_read = 0; bus4.mem_write = 0; bus4.mem_address = 0;
        bus4.mem_wdata = 0; bus4.mem_wmask = 0;
        bus1.mem_read = 0; bus1.mem_write = 0; bus1.mem_address = 0;
        bus1.mem_wdata = 0; bus1.mem_wmask = 0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp", {15'd0, bus4.mem_resp}, 16'd0);
        check("rst_rdata", bus4.mem_rdata, 16'h0000);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("idle_resp", {15'd0, bus4.mem_resp}, 16'd0);
        end

        // Write then read
        access4(0, 1, 16'h0010, 16'hBEEF, 2'b11, 1, 16'hBEEF, "wr10");
        access4(1, 0, 16'h0010, 16'h0000, 2'b00, 1, 16'hBEEF, "rd10");

        // Byte masking
        access4(0, 1, 16'h0020, 16'h1234, 2'b11, 1, 16'h1234, "pre20");
        access4(0, 1, 16'h0020, 16'hABCD, 2'b10, 1, 16'hAB34, "wr_hi");
        access4(1, 0, 16'h0020, 16'h0000, 2'b00, 1, 16'hAB34, "rd_hi");
        access4(0, 1, 16'h0020, 16'h0000, 2'b01, 1, 16'hAB00, "wr_lo");
        access4(1, 0, 16'h0020, 16'h0000, 2'b00, 1, 16'hAB00, "rd_lo");
        access4(0, 1, 16'h0020, 16'hFFFF, 2'b00, 1, 16'hAB00, "wr_none");
        access4(1, 0, 16'h0020, 16'h0000, 2'b00, 1, 16'hAB00, "rd_none");

        // Address handling
        access4(1, 0, 16'h0021, 16'h0000, 2'b00, 1, 16'hAB00, "rd_odd");
        access4(0, 1, 16'h0220, 16'h7777, 2'b11, 1, 16'h7777, "wr_alias");
        access4(1, 0, 16'h0020, 16'h0000, 2'b00, 1, 16'h7777, "rd_alias");
        access4(1, 1, 16'h0040, 16'h4242, 2'b11, 1, 16'h4242, "rw_both");
        access4(1, 0, 16'h0040, 16'h0000, 2'b00, 1, 16'h4242, "rd_both");

        // Request lines dropped right after acceptance still complete
        access4(0, 1, 16'h0050, 16'h9999, 2'b11, 0, 16'h9999, "wr_drop");
        access4(1, 0, 16'h0050, 16'h0000, 2'b00, 0, 16'h9999, "rd_drop");

        // LATENCY=1 back-to-back
        @(posedge clk); #1;
        bus1.mem_write = 1; bus1.mem_address = 16'h0010;
        bus1.mem_wdata = 16'h1357; bus1.mem_wmask = 2'b11;
        @(posedge clk); #1;
        check("l1_resp_c1", {15'd0, bus1.mem_resp}, 16'd1);
        check("l1_rdata_c1", bus1.mem_rdata, 16'h1357);
        bus1.mem_write = 0; bus1.mem_read = 1;
        for (int c = 2; c <= 8; c++) begin
            @(posedge clk); #1;
            check("l1_resp", {15'd0, bus1.mem_resp}, {15'd0, (c % 2 == 1)});
            check("l1_rdata", bus1.mem_rdata, 16'h1357);
        end
        bus1.mem_read = 0;

        // Reset mid-write
        access4(0, 1, 16'h0030, 16'h1111, 2'b11, 1, 16'h1111, "pre30");
        @(posedge clk); #1;
        bus4.mem_write = 1; bus4.mem_address = 16'h0030;
        bus4.mem_wdata = 16'h5555; bus4.mem_wmask = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus4.mem_write = 0;
        check("midrst_rdata", bus4.mem_rdata, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            check("midrst_resp", {15'd0, bus4.mem_resp}, 16'd0);
            @(posedge clk); #1;
        end
        access4(1, 0, 16'h0030, 16'h0000, 2'b00, 1, 16'h1111, "rd30");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
